// File: rtl/layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// layer_sequencer_if
// Datapath-side bus between the layer sequencer and the accelerator datapath
// (instruction RAM, address generator, weight ROM, neuron RAM, MAC core).
//   instr_addr / instr_data        : instruction RAM read (combinational data)
//   nk                             : latched Nk of the current pass
//   weight_base                    : weight ROM read base
//   neuro_read_base/write_base     : neuron RAM ping-pong buffer bases
//   ag_reset / ag_read             : address generator reset / load window
//   ag_finished                    : address generator pass complete
//   mac_reset                      : MAC accumulator clear
//   neuro_wre                      : neuron RAM write enable
// master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface layer_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] instr_addr;
  logic [ADDR_W-1:0] instr_data;
  logic [ADDR_W-1:0] nk;
  logic [ADDR_W-1:0] weight_base;
  logic [ADDR_W-1:0] neuro_read_base;
  logic [ADDR_W-1:0] neuro_write_base;
  logic              ag_reset;
  logic              ag_read;
  logic              ag_finished;
  logic              mac_reset;
  logic              neuro_wre;

  modport master (
    output instr_addr, nk, weight_base, neuro_read_base, neuro_write_base,
    output ag_reset, ag_read, mac_reset, neuro_wre,
    input  instr_data, ag_finished
  );

  modport slave (
    input  instr_addr, nk, weight_base, neuro_read_base, neuro_write_base,
    input  ag_reset, ag_read, mac_reset, neuro_wre,
    output instr_data, ag_finished
  );
endinterface

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Top-level controller for the neural accelerator datapath. Walks the
// instruction RAM one pass at a time, latches each pass's Nk, opens the
// load/MAC-reset window, waits for the address generator to finish, commits
// the MAC result to neuron RAM and ping-pongs the neuron buffers.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, returns to IDLE
//   start      : 1-cycle run request, sampled only in IDLE
//   num_passes : pass count, sampled with start
//   dp         : datapath bus (layer_sequencer_if.master)
//   busy       : high in every state except IDLE
//   done       : 1-cycle pulse at run completion
//   pass_idx   : current pass index
// All control outputs are registered from the next state (Moore).
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int BUF_A_BASE  = 0,
  parameter int BUF_B_BASE  = 10,
  parameter int LOAD_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          num_passes,
  layer_sequencer_if.master   dp,
  output logic                busy,
  output logic                done,
  output logic [3:0]          pass_idx
);

  localparam int CNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BUF_A_BASE);
  localparam logic [ADDR_W-1:0] BASE_B    = ADDR_W'(BUF_B_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_RUN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_load_cnt;
  logic [ADDR_W-1:0] r_nk, r_weight_base, r_rd_base, r_wr_base;
  logic [3:0]        r_pass_idx, r_num_passes;
  logic              r_ag_reset, r_ag_read, r_mac_reset, r_neuro_wre, r_busy, r_done;
  logic              w_ag_reset, w_ag_read, w_mac_reset, w_neuro_wre, w_busy, w_done;
  logic              w_last_pass;

  assign w_last_pass = ((r_pass_idx + 4'd1) == r_num_passes);

  // State register plus output registers (outputs track the state entered).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ag_reset  <= 1'b1;
      r_ag_read   <= 1'b0;
      r_mac_reset <= 1'b0;
      r_neuro_wre <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ag_reset  <= w_ag_reset;
      r_ag_read   <= w_ag_read;
      r_mac_reset <= w_mac_reset;
      r_neuro_wre <= w_neuro_wre;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (num_passes == 4'd0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = (dp.instr_data == '0) ? S_NEXT : S_LOAD;
      S_LOAD:  if (r_load_cnt == '0) w_next = S_RUN;
      S_RUN:   if (dp.ag_finished) w_next = S_WRITE;
      S_WRITE: w_next = S_NEXT;
      S_NEXT:  w_next = w_last_pass ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode of the state being entered; registered above so each
  // output is valid exactly in the cycle its state is occupied.
  always_comb begin
    w_ag_read   = (w_next == S_LOAD);
    w_mac_reset = (w_next == S_LOAD);
    w_ag_reset  = (w_next == S_LOAD) && (r_state != S_LOAD);
    w_neuro_wre = (w_next == S_WRITE);
    w_busy      = (w_next != S_IDLE);
    w_done      = (w_next == S_DONE);
  end

  // Pass bookkeeping: Nk, weight base, ping-pong buffers, pass index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nk          <= '0;
      r_weight_base <= '0;
      r_rd_base     <= '0;
      r_wr_base     <= BASE_B;
      r_pass_idx    <= '0;
      r_num_passes  <= '0;
      r_load_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pass_idx    <= '0;
            r_num_passes  <= num_passes;
            r_weight_base <= '0;
            r_rd_base     <= BASE_A;
            r_wr_base     <= BASE_B;
          end
        end
        S_FETCH: begin
          r_nk       <= dp.instr_data;
          r_load_cnt <= LOAD_LAST;
        end
        S_LOAD: r_load_cnt <= r_load_cnt - CNT_W'(1);
        S_NEXT: begin
          // A skipped pass latched nk=0, so the base advance is a no-op.
          r_weight_base <= r_weight_base + r_nk;
          r_rd_base     <= r_wr_base;
          r_wr_base     <= r_rd_base;
          r_pass_idx    <= r_pass_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign dp.instr_addr       = ADDR_W'(r_pass_idx);
  assign dp.nk               = r_nk;
  assign dp.weight_base      = r_weight_base;
  assign dp.neuro_read_base  = r_rd_base;
  assign dp.neuro_write_base = r_wr_base;
  assign dp.ag_reset         = r_ag_reset;
  assign dp.ag_read          = r_ag_read;
  assign dp.mac_reset        = r_mac_reset;
  assign dp.neuro_wre        = r_neuro_wre;
  assign busy                = r_busy;
  assign done                = r_done;
  assign pass_idx            = r_pass_idx;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Self-checking bench for layer_sequencer. A table of run cases drives the
// sequencer against a behavioural instruction RAM and address generator;
// expected neuron-RAM writes are queued when a run is started and popped as
// the DUT raises neuro_wre. A hand-written sequence covers reset mid-RUN,
// start during RUN and start coincident with reset.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] num_passes;
  logic       busy, done;
  logic [3:0] pass_idx;

  layer_sequencer_if #(.ADDR_W(8)) dp ();

  logic [7:0] instr_mem [16];
  assign dp.instr_data = instr_mem[dp.instr_addr[3:0]];

  layer_sequencer #(
    .ADDR_W(8), .BUF_A_BASE(0), .BUF_B_BASE(10), .LOAD_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
    .dp(dp), .busy(busy), .done(done), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      np;
    logic [3:0][7:0] nk;
    logic [7:0]      r;
    logic            noise;
    logic [7:0]      exp_wb;
  } case_t;

  typedef struct packed {
    logic [3:0] p;
    logic [7:0] wb, rb, wrb, nk;
  } wr_t;

  case_t cases [6];
  wr_t   exp_q [$];
  int    total = 0;
  int    bad   = 0;
  int    r_tgt, run_cnt;
  bit    noise, prev_read, in_run;

  function automatic case_t mk(int np, int n0, int n1, int n2, int n3,
                               int r, bit nz, int ewb);
    case_t c;
    c.np = 4'(np);
    c.nk[0] = 8'(n0); c.nk[1] = 8'(n1); c.nk[2] = 8'(n2); c.nk[3] = 8'(n3);
    c.r = 8'(r); c.noise = nz; c.exp_wb = 8'(ewb);
    return c;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Address generator model, called at each negedge: detects the first RUN
  // cycle (ag_read just fell) and raises ag_finished on RUN cycle r_tgt.
  // With noise set, ag_finished is also held high whenever not in RUN.
  task automatic drive_fin();
    if (prev_read && !dp.ag_read) begin
      in_run = 1'b1; run_cnt = 1;
    end else if (in_run) begin
      run_cnt++;
    end
    if (in_run && run_cnt == r_tgt) begin
      dp.ag_finished = 1'b1; in_run = 1'b0;
    end else begin
      dp.ag_finished = !in_run && noise;
    end
    prev_read = dp.ag_read;
  endtask

  task automatic run_case(input case_t c);
    int  wb, rb, wrb, n_act, exp_busy, nb, nr, nm, na, nw, nkv;
    bit  got_done;
    wr_t e;
    for (int i = 0; i < 16; i++) instr_mem[i] = (i < 4) ? c.nk[i] : 8'd0;
    exp_q.delete();
    wb = 0; rb = 0; wrb = 10; n_act = 0; exp_busy = 1;
    for (int p = 0; p < int'(c.np); p++) begin
      nkv = int'(c.nk[p]);
      if (nkv != 0) begin
        exp_q.push_back('{p: 4'(p), wb: 8'(wb), rb: 8'(rb), wrb: 8'(wrb), nk: 8'(nkv)});
        n_act++;
        exp_busy += 6 + int'(c.r);
      end else begin
        exp_busy += 2;
      end
      wb = (wb + nkv) % 256;
      begin int t; t = rb; rb = wrb; wrb = t; end
    end
    r_tgt = int'(c.r); noise = c.noise; prev_read = 1'b0; in_run = 1'b0;
    nb = 0; nr = 0; nm = 0; na = 0; nw = 0; got_done = 1'b0;

    start = 1'b1; num_passes = c.np;
    @(negedge clk);
    start = 1'b0;
    check("first_pass_idx", int'(pass_idx), 0);
    for (int cyc = 0; cyc < 500 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      drive_fin();
      if (busy)         nb++;
      if (dp.ag_read)   nr++;
      if (dp.mac_reset) nm++;
      if (dp.ag_reset)  na++;
      if (dp.neuro_wre) begin
        nw++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_pass_idx", int'(pass_idx),            int'(e.p));
          check("wr_weight",   int'(dp.weight_base),      int'(e.wb));
          check("wr_rd_base",  int'(dp.neuro_read_base),  int'(e.rb));
          check("wr_wr_base",  int'(dp.neuro_write_base), int'(e.wrb));
          check("wr_nk",       int'(dp.nk),               int'(e.nk));
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("final_weight",   int'(dp.weight_base),      int'(c.exp_wb));
        check("final_pass_idx", int'(pass_idx),            int'(c.np));
        check("final_rd_base",  int'(dp.neuro_read_base),  rb);
        check("final_wr_base",  int'(dp.neuro_write_base), wrb);
      end
    end
    check("done_seen",      int'(got_done), 1);
    check("write_count",    nw, n_act);
    check("queue_left",     exp_q.size(), 0);
    check("busy_cycles",    nb, exp_busy);
    check("ag_read_cycles", nr, 3 * n_act);
    check("mac_rst_cycles", nm, 3 * n_act);
    check("ag_rst_pulses",  na, n_act);
    @(negedge clk);
    dp.ag_finished = 1'b0; noise = 1'b0;
    check("done_width",      int'(done), 0);
    check("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int  ndone;
    bit  reached;
    reset = 1'b1; start = 1'b0; num_passes = '0; dp.ag_finished = 1'b0;
    noise = 1'b0; prev_read = 1'b0; in_run = 1'b0; run_cnt = 0; r_tgt = 0;
    for (int i = 0; i < 16; i++) instr_mem[i] = 8'd0;

    cases[0] = mk(1,   4,  0,  0, 0, 6, 1'b0,  4);  // single pass, done 12 after FETCH
    cases[1] = mk(3,   3,  5,  2, 0, 1, 1'b0, 10);  // three passes, R=1
    cases[2] = mk(3,   4,  0,  6, 0, 2, 1'b0, 10);  // zero-Nk skip
    cases[3] = mk(0,   7,  0,  0, 0, 1, 1'b0,  0);  // num_passes=0
    cases[4] = mk(3, 200, 50, 10, 0, 1, 1'b0,  4);  // weight base 250 + 10 wraps
    cases[5] = mk(4,   1,  2,  3, 4, 3, 1'b1, 10);  // ag_finished outside RUN

    repeat (3) @(negedge clk);
    check("rst_busy",     int'(busy), 0);
    check("rst_done",     int'(done), 0);
    check("rst_ag_reset", int'(dp.ag_reset), 1);
    check("rst_ag_read",  int'(dp.ag_read), 0);
    check("rst_wre",      int'(dp.neuro_wre), 0);
    check("rst_wr_base",  int'(dp.neuro_write_base), 10);
    check("rst_instr",    int'(dp.instr_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ag_reset", int'(dp.ag_reset), 0);

    for (int k = 0; k < 6; k++) run_case(cases[k]);

    // Reset mid-RUN of pass 1 of 3, with an ignored start during pass 0's RUN.
    instr_mem[0] = 8'd3; instr_mem[1] = 8'd5; instr_mem[2] = 8'd2; instr_mem[3] = 8'd0;
    r_tgt = 8; noise = 1'b0; prev_read = 1'b0; in_run = 1'b0;
    start = 1'b1; num_passes = 4'd3;
    @(negedge clk);
    ndone = 0; reached = 1'b0;
    for (int cyc = 0; cyc < 300 && !reached; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      drive_fin();
      if (done) ndone++;
      if (in_run && pass_idx == 4'd0 && run_cnt == 2) begin
        start = 1'b1; num_passes = 4'd1;
      end
      if (in_run && pass_idx == 4'd1 && run_cnt == 4) reached = 1'b1;
    end
    check("reached_pass1_run", int'(reached), 1);
    check("no_early_done",     ndone, 0);
    check("busy_in_run",       int'(busy), 1);
    reset = 1'b1; start = 1'b1; num_passes = 4'd2; dp.ag_finished = 1'b0;
    @(negedge clk);
    check("mid_busy",     int'(busy), 0);
    check("mid_done",     int'(done), 0);
    check("mid_wre",      int'(dp.neuro_wre), 0);
    check("mid_ag_read",  int'(dp.ag_read), 0);
    check("mid_mac_rst",  int'(dp.mac_reset), 0);
    check("mid_ag_reset", int'(dp.ag_reset), 1);
    check("mid_pass_idx", int'(pass_idx), 0);
    check("mid_weight",   int'(dp.weight_base), 0);
    check("mid_rd_base",  int'(dp.neuro_read_base), 0);
    check("mid_wr_base",  int'(dp.neuro_write_base), 10);
    check("mid_nk",       int'(dp.nk), 0);
    @(negedge clk);
    check("rst_start_busy", int'(busy), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_ag_reset", int'(dp.ag_reset), 0);
    check("post_busy",     int'(busy), 0);
    check("post_done",     int'(done), 0);
    run_case(cases[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
